// File: rtl/bit_serializer_if.sv
// Parallel word handshake into the bit serializer.
// Upstream (master) drives din/din_valid; the serializer (slave) drives din_ready.
interface bit_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in, one registered bit per clock out.
// Back-to-back words stream with no idle gap between them.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  bit_serializer_if.slave up,
  output logic            ser_out,
  output logic            ser_valid,
  output logic            last_bit,
  output logic            busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_nx;
  logic            ser_q, ser_d;
  logic            sv_q, sv_d;
  logic            lb_q, lb_d;
  logic            at_last;
  logic            mid_word;
  logic            accept;

  function automatic logic pick(
    input logic [WIDTH-1:0] w,
    input logic [CW-1:0]    c
  );
    logic [CW-1:0] idx;
    idx = MSB_FIRST ? LAST - c : c;
    return w[idx];
  endfunction

  assign at_last  = (cnt_q == LAST);
  assign mid_word = (state_q == SHIFT) && !at_last;
  assign cnt_nx   = cnt_q + 1'b1;

  assign up.din_ready = !reset &&
                        ((state_q == IDLE) || at_last);
  assign accept = up.din_valid & up.din_ready;

  // ready only opens on the last bit, so accept and mid_word never overlap
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    sv_d    = sv_q;
    lb_d    = lb_q;
    unique case (1'b1)
      accept: begin
        state_d = SHIFT;
        word_d  = up.din;
        cnt_d   = '0;
        ser_d   = pick(up.din, '0);
        sv_d    = 1'b1;
        lb_d    = 1'b0;
      end
      mid_word: begin
        cnt_d = cnt_nx;
        ser_d = pick(word_q, cnt_nx);
        sv_d  = 1'b1;
        lb_d  = (cnt_nx == LAST);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ser_d   = IDLE_BIT;
        sv_d    = 1'b0;
        lb_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      ser_q   <= IDLE_BIT;
      sv_q    <= 1'b0;
      lb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      sv_q    <= sv_d;
      lb_q    <= lb_d;
    end
  end

  assign ser_out   = ser_q;
  assign ser_valid = sv_q;
  assign last_bit  = lb_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed vector table, hand sequences and
// random traffic against a queue-based bit-stream model.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) i0 ();
  bit_serializer_if #(.WIDTH(4)) i1 ();

  logic s0, v0o, l0, b0;
  logic s1, v1o, l1, b1;

  bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) u0 (
    .clk(clk), .reset(rst), .up(i0),
    .ser_out(s0), .ser_valid(v0o),
    .last_bit(l0), .busy(b0)
  );

  bit_serializer #(
    .WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
  ) u1 (
    .clk(clk), .reset(rst), .up(i1),
    .ser_out(s1), .ser_valid(v1o),
    .last_bit(l1), .busy(b1)
  );

  int errors = 0;
  int checks = 0;

  // model: bits still to be shown for the word in flight, plus current output
  bit   q0[$];
  bit   q1[$];
  logic c0b = 1'b0, c0v = 1'b0, c0l = 1'b0;
  logic c1b = 1'b1, c1v = 1'b0, c1l = 1'b0;

  logic [3:0] win;
  int nbits, hits, svcnt, run, maxrun;

  typedef struct {
    logic       r;
    logic       sel;
    logic       v;
    logic [7:0] d;
    logic [4:0] e;
  } vec_t;
  vec_t tv[$];

  function automatic void row(
    input logic r, input logic sel, input logic v,
    input logic [7:0] d, input logic [4:0] e
  );
    vec_t t;
    t.r = r; t.sel = sel; t.v = v; t.d = d; t.e = e;
    tv.push_back(t);
  endfunction

  task automatic check(input string name,
                       input logic [4:0] got,
                       input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic checkn(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic clear_det();
    win = 4'b0; nbits = 0; hits = 0;
    svcnt = 0; run = 0; maxrun = 0;
  endtask

  task automatic tick(input logic r,
                      input logic va, input logic [7:0] da,
                      input logic vb, input logic [3:0] db);
    logic ra, rb;
    rst = r;
    i0.din_valid = va; i0.din = da;
    i1.din_valid = vb; i1.din = db;
    ra = !r && (q0.size() == 0);
    rb = !r && (q1.size() == 0);
    @(posedge clk);
    if (r) begin
      q0.delete();
      q1.delete();
    end else begin
      if (va && ra) for (int i = 7; i >= 0; i--) q0.push_back(da[i]);
      if (vb && rb) for (int i = 0; i < 4; i++) q1.push_back(db[i]);
    end
    c0v = (q0.size() > 0);
    c0b = c0v ? q0.pop_front() : 1'b0;
    c0l = c0v && (q0.size() == 0);
    c1v = (q1.size() > 0);
    c1b = c1v ? q1.pop_front() : 1'b1;
    c1l = c1v && (q1.size() == 0);
    @(negedge clk);
    check("model_w8", {i0.din_ready, s0, v0o, l0, b0},
          {!r && (q0.size() == 0), c0b, c0v, c0l, c0v});
    check("model_w4", {i1.din_ready, s1, v1o, l1, b1},
          {!r && (q1.size() == 0), c1b, c1v, c1l, c1v});
    if (v0o) begin
      win = {win[2:0], s0};
      nbits++; svcnt++; run++;
      if (run > maxrun) maxrun = run;
      if (nbits >= 4 && win == 4'b1001) hits++;
    end else begin
      run = 0;
    end
  endtask

  initial begin
    logic       pa, pb, va, vb, r, ra;
    logic [7:0] da;
    logic [3:0] db;

    // exp = {din_ready, ser_out, ser_valid, last_bit, busy}
    // 0x90 MSB first
    row(0,0,1,8'h90,5'b01101);
    row(0,0,0,8'h00,5'b00101);
    row(0,0,0,8'h00,5'b00101);
    row(0,0,0,8'h00,5'b01101);
    row(0,0,0,8'h00,5'b00101);
    row(0,0,0,8'h00,5'b00101);
    row(0,0,0,8'h00,5'b00101);
    row(0,0,0,8'h00,5'b10111);
    row(0,0,0,8'h00,5'b10000);
    // 0x01 then 0xAA held while busy
    row(0,0,1,8'h01,5'b00101);
    for (int k = 0; k < 6; k++) row(0,0,1,8'hAA,5'b00101);
    row(0,0,1,8'hAA,5'b11111);
    row(0,0,1,8'hAA,5'b01101);
    row(0,0,0,8'hFF,5'b00101);
    row(0,0,0,8'hFF,5'b01101);
    row(0,0,0,8'hFF,5'b00101);
    row(0,0,0,8'hFF,5'b01101);
    row(0,0,0,8'hFF,5'b00101);
    row(0,0,0,8'hFF,5'b01101);
    row(0,0,0,8'hFF,5'b10111);
    row(0,0,0,8'hFF,5'b10000);
    // reset in the middle of 0xFF, then 0x81 shifts from its first bit
    row(0,0,1,8'hFF,5'b01101);
    for (int k = 0; k < 3; k++) row(0,0,0,8'h00,5'b01101);
    row(1,0,1,8'h00,5'b00000);
    row(0,0,1,8'h81,5'b01101);
    for (int k = 0; k < 6; k++) row(0,0,0,8'h00,5'b00101);
    row(0,0,0,8'h00,5'b11111);
    row(0,0,0,8'h00,5'b10000);
    // long idle
    for (int k = 0; k < 20; k++) row(0,0,0,8'h5A,5'b10000);
    // 4-bit LSB first, idle level 1
    row(0,1,1,8'h06,5'b00101);
    row(0,1,0,8'h0F,5'b01101);
    row(0,1,0,8'h0F,5'b01101);
    row(0,1,0,8'h0F,5'b10111);
    row(0,1,1,8'h08,5'b00101);
    row(0,1,0,8'h00,5'b00101);
    row(0,1,0,8'h00,5'b00101);
    row(0,1,0,8'h00,5'b11111);
    row(0,1,0,8'h00,5'b11000);

    clear_det();
    tick(1, 0, 8'h00, 0, 4'h0);
    tick(1, 0, 8'h00, 0, 4'h0);
    check("reset_w8", {i0.din_ready, s0, v0o, l0, b0}, 5'b00000);
    check("reset_w4", {i1.din_ready, s1, v1o, l1, b1}, 5'b01000);

    foreach (tv[k]) begin
      tick(tv[k].r, !tv[k].sel && tv[k].v, tv[k].d,
           tv[k].sel && tv[k].v, tv[k].d[3:0]);
      check($sformatf("tbl%0d", k),
            tv[k].sel ? {i1.din_ready, s1, v1o, l1, b1}
                      : {i0.din_ready, s0, v0o, l0, b0},
            tv[k].e);
    end

    // single word with a 1001 pattern
    clear_det();
    tick(0, 1, 8'h90, 0, 4'h0);
    for (int k = 0; k < 9; k++) tick(0, 0, 8'h00, 0, 4'h0);
    checkn("det_90", hits, 1);
    checkn("sv_90", svcnt, 8);

    // pattern across a word boundary, second word held until taken
    clear_det();
    tick(0, 1, 8'h01, 0, 4'h0);
    for (int k = 0; k < 8; k++) tick(0, 1, 8'h20, 0, 4'h0);
    for (int k = 0; k < 9; k++) tick(0, 0, 8'h00, 0, 4'h0);
    checkn("det_cross", hits, 1);
    checkn("sv_b2b", svcnt, 16);
    checkn("run_b2b", maxrun, 16);

    // random traffic; upstream holds a word until it is taken
    pa = 1'b0; pb = 1'b0;
    va = 1'b0; vb = 1'b0;
    da = '0;   db = '0;
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 63) == 0);
      if (!pa) begin
        va = ($urandom_range(0, 3) != 0);
        da = 8'($urandom);
      end
      if (!pb) begin
        vb = ($urandom_range(0, 3) != 0);
        db = 4'($urandom);
      end
      ra = !r && (q0.size() == 0);
      pa = va && !ra;
      pb = vb && !(!r && (q1.size() == 0));
      tick(r, va, da, vb, db);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
